// File: rtl/decode_ctrl_stage_if.sv
// decode_ctrl_stage_if: ID-to-EX boundary bundle for decode_ctrl_stage.
// Parameters: PC_W (pc_d/ex_pc/exc_pc width), ALUCTR_W, NPCOP_W.
// Signals:
//   ID side   : id_valid, instr[31:0], pc_d (to stage); id_ready (from stage)
//   EX control: ex_stall, flush (to stage); ex_valid, ex_alusrc, ex_memtoreg,
//               ex_regwr, ex_memwr, ex_extop, ex_branch, ex_aluctr, ex_npcop,
//               ex_rs, ex_rt, ex_wr_addr, ex_pc (from stage)
//   Trap      : exc_ack (to stage); exc_req, exc_pc (from stage)
// Modports: slave = the decode stage, master = the surrounding pipeline.
interface decode_ctrl_stage_if #(
    parameter int PC_W     = 32,
    parameter int ALUCTR_W = 4,
    parameter int NPCOP_W  = 4
);
    logic                id_valid;
    logic [31:0]         instr;
    logic [PC_W-1:0]     pc_d;
    logic                id_ready;
    logic                ex_stall;
    logic                flush;
    logic                ex_valid;
    logic                ex_alusrc;
    logic                ex_memtoreg;
    logic                ex_regwr;
    logic                ex_memwr;
    logic                ex_extop;
    logic                ex_branch;
    logic [ALUCTR_W-1:0] ex_aluctr;
    logic [NPCOP_W-1:0]  ex_npcop;
    logic [4:0]          ex_rs;
    logic [4:0]          ex_rt;
    logic [4:0]          ex_wr_addr;
    logic [PC_W-1:0]     ex_pc;
    logic                exc_req;
    logic [PC_W-1:0]     exc_pc;
    logic                exc_ack;

    modport slave (
        input  id_valid, instr, pc_d, ex_stall, flush, exc_ack,
        output id_ready, ex_valid, ex_alusrc, ex_memtoreg, ex_regwr, ex_memwr,
               ex_extop, ex_branch, ex_aluctr, ex_npcop, ex_rs, ex_rt,
               ex_wr_addr, ex_pc, exc_req, exc_pc
    );

    modport master (
        output id_valid, instr, pc_d, ex_stall, flush, exc_ack,
        input  id_ready, ex_valid, ex_alusrc, ex_memtoreg, ex_regwr, ex_memwr,
               ex_extop, ex_branch, ex_aluctr, ex_npcop, ex_rs, ex_rt,
               ex_wr_addr, ex_pc, exc_req, exc_pc
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered ID-stage decoder feeding the ID/EX register.
// Decodes instr, captures the control word into EX one cycle later, stalls on
// load-use hazards and raises an undefined-instruction trap via exc_req/exc_ack.
// Ports:
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : decode_ctrl_stage_if.slave (ID inputs, EX control word, trap handshake)
// Build option: define CTRL_UNDEF_TRAP_EN to include the trap FSM; otherwise
// undefined instructions become bubbles and exc_req/exc_pc stay 0.
module decode_ctrl_stage #(
    parameter int PC_W     = 32,
    parameter int ALUCTR_W = 4,
    parameter int NPCOP_W  = 4
) (
    input logic                clk,
    input logic                rst_n,
    decode_ctrl_stage_if.slave bus
);
    localparam logic [ALUCTR_W-1:0] ALU_AND   = ALUCTR_W'(4'b0000);
    localparam logic [ALUCTR_W-1:0] ALU_OR    = ALUCTR_W'(4'b0001);
    localparam logic [ALUCTR_W-1:0] ALU_ADD   = ALUCTR_W'(4'b0010);
    localparam logic [ALUCTR_W-1:0] ALU_XOR   = ALUCTR_W'(4'b0011);
    localparam logic [ALUCTR_W-1:0] ALU_ORI   = ALUCTR_W'(4'b0100);
    localparam logic [ALUCTR_W-1:0] ALU_ADDIU = ALUCTR_W'(4'b0101);
    localparam logic [ALUCTR_W-1:0] ALU_SUB   = ALUCTR_W'(4'b0110);
    localparam logic [ALUCTR_W-1:0] ALU_ADDI  = ALUCTR_W'(4'b0111);
    localparam logic [ALUCTR_W-1:0] ALU_SLT   = ALUCTR_W'(4'b1001);
    localparam logic [ALUCTR_W-1:0] ALU_LUI   = ALUCTR_W'(4'b1111);

    localparam logic [NPCOP_W-1:0] NPC_JUMP = NPCOP_W'(4'b0000);
    localparam logic [NPCOP_W-1:0] NPC_JAL  = NPCOP_W'(4'b0001);
    localparam logic [NPCOP_W-1:0] NPC_BEQ  = NPCOP_W'(4'b0010);
    localparam logic [NPCOP_W-1:0] NPC_BNE  = NPCOP_W'(4'b0011);
    localparam logic [NPCOP_W-1:0] NPC_JR   = NPCOP_W'(4'b1000);
    localparam logic [NPCOP_W-1:0] NPC_ADD4 = NPCOP_W'(4'b1111);

    typedef struct packed {
        logic                valid;
        logic                alusrc;
        logic                memtoreg;
        logic                regwr;
        logic                memwr;
        logic                extop;
        logic                branch;
        logic [ALUCTR_W-1:0] aluctr;
        logic [NPCOP_W-1:0]  npcop;
        logic [4:0]          rs;
        logic [4:0]          rt;
        logic [4:0]          wr_addr;
        logic [PC_W-1:0]     pc;
    } ctrl_t;

    typedef enum logic {IDLE, TRAP} state_t;

    logic [5:0]      op;
    logic [5:0]      func;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    ctrl_t           dec;
    ctrl_t           bubble;
    ctrl_t           ex_d;
    ctrl_t           ex_q;
    logic            dec_undef;
    logic            rt_used;
    logic            hazard;
    logic            id_ready;
    logic            accept;
    state_t          state_q;
    logic            exc_req_q;
    logic [PC_W-1:0] exc_pc_q;

    assign op   = bus.instr[31:26];
    assign rs   = bus.instr[25:21];
    assign rt   = bus.instr[20:16];
    assign rd   = bus.instr[15:11];
    assign func = bus.instr[5:0];

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.npcop   = NPC_ADD4;
        dec.rs      = rs;
        dec.rt      = rt;
        dec.pc      = bus.pc_d;
        dec_undef   = 1'b0;
        rt_used     = (op == 6'b000000);
        case (op)
            6'b000000: begin
                dec.regwr   = 1'b1;
                dec.wr_addr = rd;
                case (func)
                    6'b100000: dec.aluctr = ALU_ADD;
                    6'b100010: dec.aluctr = ALU_SUB;
                    6'b100100: dec.aluctr = ALU_AND;
                    6'b100101: dec.aluctr = ALU_OR;
                    6'b101010: dec.aluctr = ALU_SLT;
                    6'b100110: dec.aluctr = ALU_XOR;
                    6'b001000: begin
                        dec.npcop   = NPC_JR;
                        dec.regwr   = 1'b0;
                        dec.wr_addr = '0;
                    end
                    // An all-zero word is the NOP; any other unknown func traps.
                    default: begin
                        dec.regwr = 1'b0;
                        dec_undef = |bus.instr;
                    end
                endcase
            end
            6'b001001: begin
                dec.alusrc  = 1'b1;
                dec.regwr   = 1'b1;
                dec.wr_addr = rt;
                dec.extop   = 1'b1;
                dec.aluctr  = ALU_ADDIU;
            end
            6'b001000: begin
                dec.alusrc  = 1'b1;
                dec.regwr   = 1'b1;
                dec.wr_addr = rt;
                dec.aluctr  = ALU_ADDI;
            end
            6'b001101: begin
                dec.alusrc  = 1'b1;
                dec.regwr   = 1'b1;
                dec.wr_addr = rt;
                dec.aluctr  = ALU_ORI;
            end
            6'b001111: begin
                dec.alusrc  = 1'b1;
                dec.regwr   = 1'b1;
                dec.wr_addr = rt;
                dec.extop   = 1'b1;
                dec.aluctr  = ALU_LUI;
            end
            6'b100011: begin
                dec.alusrc   = 1'b1;
                dec.regwr    = 1'b1;
                dec.wr_addr  = rt;
                dec.extop    = 1'b1;
                dec.memtoreg = 1'b1;
                dec.aluctr   = ALU_ADD;
            end
            // sw computes its address as rs+imm but writes no register.
            6'b101011: begin
                dec.alusrc = 1'b1;
                dec.memwr  = 1'b1;
                dec.extop  = 1'b1;
                dec.aluctr = ALU_ADD;
                rt_used    = 1'b1;
            end
            6'b000100: begin
                dec.extop  = 1'b1;
                dec.branch = 1'b1;
                dec.aluctr = ALU_SUB;
                dec.npcop  = NPC_BEQ;
                rt_used    = 1'b1;
            end
            6'b000101: begin
                dec.extop  = 1'b1;
                dec.branch = 1'b1;
                dec.aluctr = ALU_SUB;
                dec.npcop  = NPC_BNE;
                rt_used    = 1'b1;
            end
            6'b000010: dec.npcop = NPC_JUMP;
            6'b000011: begin
                dec.npcop   = NPC_JAL;
                dec.regwr   = 1'b1;
                dec.wr_addr = 5'd31;
            end
            default: dec_undef = 1'b1;
        endcase
    end

    always_comb begin
        bubble       = '0;
        bubble.npcop = NPC_ADD4;
    end

    // Load in EX whose result the ID instruction needs: hold ID for one cycle.
    assign hazard = ex_q.valid & ex_q.memtoreg & (ex_q.wr_addr != 5'd0) &
                    ((ex_q.wr_addr == rs) | ((ex_q.wr_addr == rt) & rt_used));

    assign id_ready = (state_q == IDLE) & ~bus.ex_stall & ~hazard;
    assign accept   = bus.id_valid & id_ready & ~bus.flush;

    // flush beats stall; with neither, only a defined accepted word is loaded.
    assign ex_d = bus.flush ? bubble :
                  bus.ex_stall ? ex_q :
                  (accept & ~dec_undef) ? dec : bubble;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_q.npcop <= NPC_ADD4;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef CTRL_UNDEF_TRAP_EN
    // Trap FSM: accept never fires while flushing, so flush suppresses new
    // traps but cannot cancel one already pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            exc_req_q <= 1'b0;
            exc_pc_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept & dec_undef) begin
                    state_q   <= TRAP;
                    exc_req_q <= 1'b1;
                    exc_pc_q  <= bus.pc_d;
                end
                TRAP: if (bus.exc_ack) begin
                    state_q   <= IDLE;
                    exc_req_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    logic unused_exc_ack;
    assign unused_exc_ack = bus.exc_ack;
    assign state_q        = IDLE;
    assign exc_req_q      = 1'b0;
    assign exc_pc_q       = '0;
`endif

    assign bus.id_ready    = id_ready;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_memtoreg = ex_q.memtoreg;
    assign bus.ex_regwr    = ex_q.regwr;
    assign bus.ex_memwr    = ex_q.memwr;
    assign bus.ex_extop    = ex_q.extop;
    assign bus.ex_branch   = ex_q.branch;
    assign bus.ex_aluctr   = ex_q.aluctr;
    assign bus.ex_npcop    = ex_q.npcop;
    assign bus.ex_rs       = ex_q.rs;
    assign bus.ex_rt       = ex_q.rt;
    assign bus.ex_wr_addr  = ex_q.wr_addr;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.exc_req     = exc_req_q;
    assign bus.exc_pc      = exc_pc_q;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed and randomized checks of decode_ctrl_stage
// against a table-driven reference model; honours CTRL_UNDEF_TRAP_EN.
module tb_decode_ctrl_stage;
    localparam int PC_W = 32, ALUCTR_W = 4, NPCOP_W = 4;
`ifdef CTRL_UNDEF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.PC_W(PC_W), .ALUCTR_W(ALUCTR_W), .NPCOP_W(NPCOP_W)) ifc ();
    decode_ctrl_stage #(.PC_W(PC_W), .ALUCTR_W(ALUCTR_W), .NPCOP_W(NPCOP_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc)
    );

    typedef struct packed {
        logic valid, alusrc, memtoreg, regwr, memwr, extop, branch;
        logic [3:0] aluctr, npcop;
        logic [4:0] rs, rt, wr;
        logic [31:0] pc;
    } ex_t;

    // One row per defined instruction; wsel: 0 none, 1 rd, 2 rt, 3 r31.
    typedef struct {
        logic [5:0] op; logic rtype; logic [5:0] fn;
        logic [3:0] alu, npc;
        logic src, m2r, rw, mw, ext, br;
        int wsel; logic rtu;
    } row_t;

    row_t tbl[$];
    ex_t m_ex;
    logic m_trap;
    logic [31:0] m_epc;
    int passed = 0, total = 0;

    function automatic row_t mk(input logic [5:0] op, input logic rtype, input logic [5:0] fn,
                                input logic [3:0] alu, input logic [3:0] npc,
                                input logic src, input logic m2r, input logic rw, input logic mw,
                                input logic ext, input logic br, input int wsel, input logic rtu);
        row_t r;
        r.op = op; r.rtype = rtype; r.fn = fn; r.alu = alu; r.npc = npc;
        r.src = src; r.m2r = m2r; r.rw = rw; r.mw = mw; r.ext = ext; r.br = br;
        r.wsel = wsel; r.rtu = rtu;
        return r;
    endfunction

    function automatic ex_t bubble_word();
        ex_t b;
        b = '0;
        b.npcop = 4'hf;
        return b;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output ex_t d,
                                       output logic undef, output logic rtu);
        d = '0;
        d.valid = 1'b1;
        d.npcop = 4'hf;
        d.rs = ins[25:21];
        d.rt = ins[20:16];
        undef = (ins != 32'h0);
        rtu = (ins[31:26] == 6'd0);
        foreach (tbl[i]) begin
            if (ins != 32'h0 && tbl[i].op == ins[31:26] && (!tbl[i].rtype || tbl[i].fn == ins[5:0])) begin
                undef = 1'b0;
                rtu = tbl[i].rtu;
                d.aluctr = tbl[i].alu; d.npcop = tbl[i].npc;
                d.alusrc = tbl[i].src; d.memtoreg = tbl[i].m2r; d.regwr = tbl[i].rw;
                d.memwr = tbl[i].mw; d.extop = tbl[i].ext; d.branch = tbl[i].br;
                d.wr = tbl[i].wsel == 1 ? ins[15:11] : tbl[i].wsel == 2 ? ins[20:16] :
                       tbl[i].wsel == 3 ? 5'd31 : 5'd0;
            end
        end
    endfunction

    function automatic ex_t dut_ex();
        return {ifc.ex_valid, ifc.ex_alusrc, ifc.ex_memtoreg, ifc.ex_regwr, ifc.ex_memwr,
                ifc.ex_extop, ifc.ex_branch, ifc.ex_aluctr, ifc.ex_npcop, ifc.ex_rs,
                ifc.ex_rt, ifc.ex_wr_addr, ifc.ex_pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic compare();
        chk("ex_word", dut_ex(), m_ex);
        chk("exc_req", ifc.exc_req, m_trap);
        chk("exc_pc", ifc.exc_pc, m_epc);
    endtask

    task automatic model_reset();
        m_ex = bubble_word();
        m_trap = 1'b0;
        m_epc = '0;
    endtask

    // Drive one cycle of inputs, check id_ready, advance the model, check after the edge.
    task automatic step(input logic idv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic stall, input logic fl, input logic ack, output logic rdy);
        ex_t d, nx;
        logic undef, rtu, haz, rdy_exp, acc, ntrap;
        logic [31:0] nepc;
        @(negedge clk);
        ifc.id_valid = idv; ifc.instr = ins; ifc.pc_d = pc;
        ifc.ex_stall = stall; ifc.flush = fl; ifc.exc_ack = ack;
        #1;
        ref_decode(ins, d, undef, rtu);
        d.pc = pc;
        haz = m_ex.valid && m_ex.memtoreg && m_ex.wr != 5'd0 &&
              (m_ex.wr == d.rs || (m_ex.wr == d.rt && rtu));
        rdy_exp = !m_trap && !stall && !haz;
        rdy = ifc.id_ready;
        chk("id_ready", rdy, rdy_exp);
        acc = idv && rdy_exp && !fl;
        nx = fl ? bubble_word() : stall ? m_ex : (acc && !undef) ? d : bubble_word();
        ntrap = m_trap;
        nepc = m_epc;
        if (TRAP_EN) begin
            if (m_trap && ack) ntrap = 1'b0;
            else if (!m_trap && acc && undef) begin
                ntrap = 1'b1;
                nepc = pc;
            end
        end
        @(posedge clk);
        #1;
        m_ex = nx; m_trap = ntrap; m_epc = nepc;
        compare();
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        row_t r;
        logic [4:0] rs, rt, rd;
        k = $urandom_range(0, 9);
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        if (k == 0) return 32'h0;
        if (k == 1) return $urandom;
        r = (k <= 3) ? tbl[11] : tbl[$urandom_range(0, tbl.size() - 1)];
        return {r.op, rs, rt, r.rtype ? {rd, 5'($urandom), r.fn} : 16'($urandom)};
    endfunction

    initial begin
        logic r;
        logic [31:0] ins;
        tbl.push_back(mk(6'h00, 1, 6'h20, 4'b0010, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h22, 4'b0110, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h24, 4'b0000, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h25, 4'b0001, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h2a, 4'b1001, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h26, 4'b0011, 4'hf, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(6'h00, 1, 6'h08, 4'b0000, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(6'h09, 0, 6'h00, 4'b0101, 4'hf, 1, 0, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(6'h08, 0, 6'h00, 4'b0111, 4'hf, 1, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(6'h0d, 0, 6'h00, 4'b0100, 4'hf, 1, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(6'h0f, 0, 6'h00, 4'b1111, 4'hf, 1, 0, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(6'h23, 0, 6'h00, 4'b0010, 4'hf, 1, 1, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(6'h2b, 0, 6'h00, 4'b0010, 4'hf, 1, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(6'h04, 0, 6'h00, 4'b0110, 4'b0010, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(6'h05, 0, 6'h00, 4'b0110, 4'b0011, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(6'h02, 0, 6'h00, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(6'h03, 0, 6'h00, 4'b0000, 4'b0001, 0, 0, 1, 0, 0, 0, 3, 0));

        ifc.id_valid = 0; ifc.instr = 0; ifc.pc_d = 0;
        ifc.ex_stall = 0; ifc.flush = 0; ifc.exc_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        chk("reset_npcop", ifc.ex_npcop, 4'hf);
        chk("reset_ready", ifc.id_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 32'h00221820, 32'h0, 0, 0, 0, r);
        chk("add_valid", ifc.ex_valid, 1);
        chk("add_aluctr", ifc.ex_aluctr, 4'b0010);
        chk("add_wr", ifc.ex_wr_addr, 3);
        chk("add_regwr", ifc.ex_regwr, 1);
        chk("add_npcop", ifc.ex_npcop, 4'hf);

        step(1, 32'h8C250000, 32'h4, 0, 0, 0, r);
        step(1, 32'h00A23020, 32'h8, 0, 0, 0, r);
        chk("lu_ready", r, 0);
        chk("lu_bubble", ifc.ex_valid, 0);
        step(1, 32'h00A23020, 32'h8, 0, 0, 0, r);
        chk("lu_ready2", r, 1);
        chk("lu_valid", ifc.ex_valid, 1);
        chk("lu_rs", ifc.ex_rs, 5);

        step(1, 32'h0C000010, 32'hC, 0, 0, 0, r);
        chk("jal_wr", ifc.ex_wr_addr, 31);
        chk("jal_regwr", ifc.ex_regwr, 1);
        chk("jal_npcop", ifc.ex_npcop, 4'b0001);

        step(1, 32'hFC000000, 32'h40, 0, 0, 0, r);
        chk("undef_req", ifc.exc_req, TRAP_EN);
        chk("undef_pc", ifc.exc_pc, TRAP_EN ? 32'h40 : 32'h0);
        chk("undef_bubble", ifc.ex_valid, 0);
        step(1, 32'h0, 32'h44, 0, 0, 0, r);
        chk("trap_ready", r, !TRAP_EN);
        step(1, 32'h0, 32'h44, 0, 0, 1, r);
        chk("trap_ready_ack", r, !TRAP_EN);
        chk("ack_clear", ifc.exc_req, 0);
        step(1, 32'h0, 32'h44, 0, 0, 0, r);
        chk("post_ack_ready", r, 1);

        step(1, 32'hAC220004, 32'h50, 0, 0, 0, r);
        chk("sw_memwr", ifc.ex_memwr, 1);
        step(1, 32'h00221820, 32'h54, 1, 0, 0, r);
        chk("stall_ready1", r, 0);
        chk("stall_hold", ifc.ex_memwr, 1);
        step(1, 32'h00221820, 32'h54, 1, 1, 0, r);
        chk("stall_ready2", r, 0);
        chk("flush_bubble", ifc.ex_valid, 0);
        step(1, 32'h00221820, 32'h54, 1, 0, 0, r);
        chk("stall_ready3", r, 0);
        chk("stall_after_flush", ifc.ex_valid, 0);

        step(1, 32'hFC000000, 32'h60, 0, 1, 0, r);
        chk("flush_no_trap", ifc.exc_req, 0);
        step(1, 32'hFC000000, 32'h60, 0, 0, 0, r);
        chk("trap_again", ifc.exc_req, TRAP_EN);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", ifc.exc_req, 0);
        chk("async_npcop", ifc.ex_npcop, 4'hf);
        chk("async_valid", ifc.ex_valid, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3000) begin
            ins = rand_instr();
            step($urandom_range(0, 9) != 0, ins, $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0), r);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered successor to the combinational main decoder. It decodes the instruction in the ID stage and captures the control word into the ID/EX pipeline register. It also detects load-use hazards and traps undefined opcodes through a request/acknowledge handshake to the exception unit. It sits between the IF/ID register and the EX stage.

## Interface
- PC_W, 32, width of pc_d, ex_pc and exc_pc
- ALUCTR_W, 4, width of ex_aluctr (minimum 4)
- NPCOP_W, 4, width of ex_npcop (minimum 4)
- clk  in  1  pipeline clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  instr/pc_d hold a real instruction
- instr  in  32  instruction word in ID
- pc_d  in  PC_W  PC of instr
- id_ready  out  1  ID instruction is consumed this cycle (combinational)
- ex_stall  in  1  EX cannot advance; hold the EX register
- flush  in  1  kill ID and EX contents (branch taken or exception)
- ex_valid, ex_alusrc, ex_memtoreg, ex_regwr, ex_memwr, ex_extop, ex_branch  out  1 each  registered control
- ex_aluctr  out  ALUCTR_W; ex_npcop  out  NPCOP_W
- ex_rs, ex_rt, ex_wr_addr  out  5 each  source registers and destination register
- ex_pc  out  PC_W
- exc_req  out  1  undefined-instruction trap pending
- exc_pc  out  PC_W  PC of the trapping instruction
- exc_ack  in  1  exception unit accepts the trap

## Operation
- ALUctr encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, ORI 0100, ADDIU 0101, SUB 0110, ADDI 0111, SLT 1001, LUI 1111.
- NPCop encodings: JUMP 0000, JAL 0001, BEQ 0010, BNE 0011, JR 1000, ADD4 1111.
- R-type (op 000000): func add/sub/and/or/slt/xor map to the ALUctr above. wr_addr=rd, regwr=1, alusrc=0.
- R-type func 001000 is jr: npcop=JR, regwr=0.
- instr==0 is a NOP: valid, regwr=0.
- Immediate forms (wr_addr=rt, alusrc=1, regwr=1):
  - addiu 001001: extop=1.
  - addi 001000: extop=0.
  - ori 001101: extop=0.
  - lui 001111: extop=1.
  - lw 100011: ALU ADD, memtoreg=1, extop=1.
- sw 101011: ALU ADD, memwr=1, regwr=0, extop=1.
- beq 000100 / bne 000101: ALU SUB, alusrc=0, extop=1, branch=1, npcop=BEQ/BNE.
- j 000010: npcop=JUMP.
- jal 000011: npcop=JAL, regwr=1, wr_addr=31.
- Any other op/func is undefined. Undefined is evaluated only when id_valid=1, so bubbles never trap.
- Load-use hazard = ex_valid & ex_memtoreg & ex_wr_addr!=0 & (ex_wr_addr==rs, or ex_wr_addr==rt with rt used). rt is used by R-type, beq, bne and sw.
- Trap FSM has two states, IDLE and TRAP:
  - IDLE→TRAP when an undefined instruction is accepted and flush=0. On that edge, exc_req←1 and exc_pc←pc_d, and a bubble enters EX.
  - TRAP→IDLE on exc_ack. exc_req←0 on the same edge.
  - flush does not cancel TRAP.
  - exc_ack in IDLE is ignored.
- id_ready = (state==IDLE) & !ex_stall & !hazard.
- accept = id_valid & id_ready & !flush.
- EX register update priority:
  1. rst_n=0
  2. flush: bubble, even if ex_stall=1
  3. ex_stall: hold
  4. hazard, TRAP, undefined, or !id_valid: bubble
  5. otherwise load the decoded word
- Bubble values: ex_valid=0, npcop=ADD4, all other ex_* fields 0.

## Timing
- Decode-to-EX latency is 1 cycle. id_ready is combinational from ex_* and inputs, with no dependency on id_valid.
- Reset values: all ex_* 0 except ex_npcop=1111. exc_req=0, exc_pc=0, state=IDLE.
- Reset asserted mid-trap returns to IDLE with exc_req=0 immediately (asynchronous).
- A load-use hazard stalls exactly 1 cycle: bubble inserted, then the instruction is accepted next cycle.
- flush together with an undefined instruction in IDLE: flush wins, no trap.
- exc_ack asserted in the same cycle exc_req rises is not possible; exc_req is registered.

## Configuration
- CTRL_UNDEF_TRAP_EN defined: trap FSM and exc_req/exc_pc are present as described.
- CTRL_UNDEF_TRAP_EN undefined:
  - undefined instructions are consumed as bubbles;
  - the FSM is removed and the state stays IDLE;
  - exc_req=0 and exc_pc=0 constantly; exc_ack is ignored.

## Test plan
- Reset release, then `add $3,$1,$2` (0x00221820) with id_valid=1 → next edge: ex_valid=1, aluctr=0010, wr_addr=3, regwr=1, npcop=1111.
- `lw $5,0($1)` followed by `add $6,$5,$2` → cycle 2: id_ready=0 and a bubble enters EX; cycle 3: add accepted with ex_rs=5.
- `jal` (op 000011) → ex_wr_addr=31, ex_regwr=1, ex_npcop=0001.
- Undefined op 111111 at pc_d=0x40 → exc_req=1 and exc_pc=0x40 after 1 edge; id_ready=0 until exc_ack; exc_req=0 the edge after exc_ack.
- ex_stall=1 for 3 cycles holding `sw` with flush pulsed in cycle 2 → ex_valid=0 after the flush edge, and id_ready=0 throughout the stall.
- Build without CTRL_UNDEF_TRAP_EN and repeat the undefined case → exc_req stays 0, a bubble enters EX, and id_ready stays 1.
